cdb_arbiter: RTL

Collects completed results from the execution units and broadcasts them on the common data bus (`cdb_ports`), which the reservation stations, ROB and rename logic snoop for tag wakeup. Each functional unit has a one-entry holding buffer. The block grants up to `PIPE_WIDTH` buffered results per cycle in round-robin order and drives them onto registered CDB ports. It sits directly downstream of the ALU/execute units that consume `execute_pkt` from the reservation station, and it closes the wakeup loop back into the reservation station.

---
 rtl/cdb_arbiter_pkg.sv | 11 +
 rtl/uarch_pkg.sv | 13 +
 rtl/cdb_arbiter_if.sv | 11 +
 rtl/cdb_arbiter_rr_select.sv | 40 ++++
 rtl/cdb_arbiter.sv | 63 ++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: index helpers shared by the arbiter and its round-robin selector
package cdb_arbiter_pkg;
  function automatic int idx_width(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int wrap_add(int a, int b, int n);
    int s;
    s = a + b;
    return s >= n ? s - n : s;
  endfunction
endpackage

// File: rtl/uarch_pkg.sv
// uarch_pkg: shared microarchitecture widths and the writeback packet format
package uarch_pkg;
  localparam int CPU_DATA_BITS = 32;
  localparam int TAG_WIDTH = 6;
  localparam int PIPE_WIDTH = 2;
  localparam int NUM_FU = 4;
  typedef struct packed {
    logic [CPU_DATA_BITS-1:0] result;
    logic [TAG_WIDTH-1:0] dest_tag;
    logic exception;
    logic is_valid;
  } writeback_packet_t;
endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: FU result handshake and CDB broadcast bundle
interface cdb_arbiter_if import uarch_pkg::*; #(
  parameter int NUM_FU = uarch_pkg::NUM_FU,
  parameter int PIPE_WIDTH = uarch_pkg::PIPE_WIDTH
) ();
  writeback_packet_t fu_result [NUM_FU];
  logic fu_cdb_rdy [NUM_FU];
  writeback_packet_t cdb_ports [PIPE_WIDTH];
  modport master (output fu_result, input fu_cdb_rdy, input cdb_ports);
  modport slave (input fu_result, output fu_cdb_rdy, output cdb_ports);
endinterface

// File: rtl/cdb_arbiter_rr_select.sv
// cdb_rr_select: picks up to PIPE_WIDTH valid holds in round-robin order from rr_ptr
module cdb_rr_select import cdb_arbiter_pkg::*; #(
  parameter int NUM_FU = 4,
  parameter int PIPE_WIDTH = 2,
  parameter int IW = idx_width(NUM_FU)
) (
  input  logic [NUM_FU-1:0] hold_valid,
  input  logic [IW-1:0] rr_ptr,
  output logic [IW-1:0] gnt_idx [PIPE_WIDTH],
  output logic [PIPE_WIDTH-1:0] gnt_vld,
  output logic [NUM_FU-1:0] grant,
  output logic [IW-1:0] rr_ptr_nxt
);
  localparam int CW = $clog2(PIPE_WIDTH + 1);
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [IW-1:0] last;
  always_comb begin
    grant = '0;
    gnt_vld = '0;
    gnt_idx = '{default: '0};
    cnt = '0;
    idx = '0;
    last = rr_ptr;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = IW'(wrap_add(int'(rr_ptr), k, NUM_FU));
      if (hold_valid[idx] && cnt < CW'(PIPE_WIDTH)) begin
        for (int p = 0; p < PIPE_WIDTH; p++)
          if (cnt == CW'(p)) begin
            gnt_idx[p] = idx;
            gnt_vld[p] = 1'b1;
          end
        grant[idx] = 1'b1;
        last = idx;
        cnt = cnt + CW'(1);
      end
    end
    rr_ptr_nxt = gnt_vld[0] ? IW'(wrap_add(int'(last), 1, NUM_FU)) : rr_ptr;
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: one-entry hold buffer per FU, round-robin grant onto registered CDB ports
module cdb_arbiter import uarch_pkg::*; import cdb_arbiter_pkg::*; #(
  parameter int NUM_FU = uarch_pkg::NUM_FU,
  parameter int PIPE_WIDTH = uarch_pkg::PIPE_WIDTH
) (
  input logic clk,
  input logic rst,
  input logic flush,
  cdb_arbiter_if.slave bus
);
  localparam int IW = idx_width(NUM_FU);
  writeback_packet_t hold_q [NUM_FU];
  writeback_packet_t hold_d [NUM_FU];
  writeback_packet_t cdb_q [PIPE_WIDTH];
  writeback_packet_t cdb_d [PIPE_WIDTH];
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, rr_ptr_nxt;
  logic [IW-1:0] gnt_idx [PIPE_WIDTH];
  logic [PIPE_WIDTH-1:0] gnt_vld;
  logic [NUM_FU-1:0] hold_valid, grant, rdy;
  cdb_rr_select #(.NUM_FU(NUM_FU), .PIPE_WIDTH(PIPE_WIDTH), .IW(IW)) u_sel (
    .hold_valid(hold_valid),
    .rr_ptr(rr_ptr_q),
    .gnt_idx(gnt_idx),
    .gnt_vld(gnt_vld),
    .grant(grant),
    .rr_ptr_nxt(rr_ptr_nxt)
  );
  always_comb begin
    hold_valid = '0;
    for (int i = 0; i < NUM_FU; i++) hold_valid[i] = hold_q[i].is_valid;
  end
  // flush overrides capture and grant; a result offered during flush is accepted and dropped
  always_comb begin
    rdy = '0;
    hold_d = hold_q;
    cdb_d = '{default: '0};
    for (int i = 0; i < NUM_FU; i++) begin
      rdy[i] = !hold_valid[i] || grant[i];
      hold_d[i] = flush ? '0
                : (bus.fu_result[i].is_valid && rdy[i]) ? bus.fu_result[i]
                : grant[i] ? '0 : hold_q[i];
    end
    for (int p = 0; p < PIPE_WIDTH; p++)
      cdb_d[p] = (flush || !gnt_vld[p]) ? '0 : hold_q[gnt_idx[p]];
    rr_ptr_d = flush ? '0 : rr_ptr_nxt;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hold_q <= '{default: '0};
      cdb_q <= '{default: '0};
      rr_ptr_q <= '0;
    end else begin
      hold_q <= hold_d;
      cdb_q <= cdb_d;
      rr_ptr_q <= rr_ptr_d;
    end
  for (genvar i = 0; i < NUM_FU; i++) begin : g_rdy
    assign bus.fu_cdb_rdy[i] = rdy[i];
  end
  for (genvar p = 0; p < PIPE_WIDTH; p++) begin : g_cdb
    assign bus.cdb_ports[p] = cdb_q[p];
  end
endmodule
